// File: rtl/scan_controller.sv
// Bit-serial scan-chain driver: streams host bytes into the chain while returning
// the displaced chain contents as bytes, one full chain length per pass.
module scan_controller #(
    parameter int DATA_BUS_WIDTH = 8,
    parameter int CHAIN_LENGTH   = 96
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    input  logic [DATA_BUS_WIDTH-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DATA_BUS_WIDTH-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      test,
    output logic                      scan_in,
    input  logic                      scan_out
);

    localparam int NUM_BYTES = CHAIN_LENGTH / DATA_BUS_WIDTH;
    localparam int BIT_W     = $clog2(DATA_BUS_WIDTH) + 1;
    localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BUS_WIDTH - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, UNLOAD} state_t;

    state_t                    state_reg, state_next;
    logic [DATA_BUS_WIDTH-1:0] shreg_reg, shreg_next;
    logic [BIT_W-1:0]          bit_cnt_reg, bit_cnt_next;
    logic [BYTE_W-1:0]         byte_cnt_reg, byte_cnt_next;
    logic                      done_reg, done_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            shreg_reg    <= '0;
            bit_cnt_reg  <= '0;
            byte_cnt_reg <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shreg_reg    <= shreg_next;
            bit_cnt_reg  <= bit_cnt_next;
            byte_cnt_reg <= byte_cnt_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        shreg_next    = shreg_reg;
        bit_cnt_next  = bit_cnt_reg;
        byte_cnt_next = byte_cnt_reg;
        done_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next    = LOAD;
                    byte_cnt_next = '0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    shreg_next   = in_data;
                    bit_cnt_next = '0;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                // Outgoing bit leaves from the LSB while the returned bit enters at the MSB,
                // so after a full byte the first captured bit sits in the LSB.
                shreg_next   = {scan_out, shreg_reg[DATA_BUS_WIDTH-1:1]};
                bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                if (bit_cnt_reg == BIT_LAST) begin
                    state_next = UNLOAD;
                end
            end
            UNLOAD: begin
                if (out_ready) begin
                    if (byte_cnt_reg == BYTE_LAST) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        byte_cnt_next = byte_cnt_reg + BYTE_W'(1);
                        state_next    = LOAD;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign in_ready  = (state_reg == LOAD);
    assign out_valid = (state_reg == UNLOAD);
    assign out_data  = shreg_reg;
    assign test      = (state_reg == SHIFT);
    assign scan_in   = test & shreg_reg[0];

endmodule

// File: tb/tb_scan_controller.sv
// Bench for scan_controller: behavioural scan chain, randomized host traffic and an
// expected-chain-contents model updated per pass.
module tb_scan_controller;

    localparam int W  = 8;
    localparam int CL = 96;
    localparam int NB = CL / W;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         busy;
    logic         done;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         test;
    logic         scan_in;
    logic         scan_out;

    scan_controller #(.DATA_BUS_WIDTH(W), .CHAIN_LENGTH(CL)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .test(test), .scan_in(scan_in), .scan_out(scan_out)
    );

    always #5 clock = ~clock;

    // Physical chain: scan_out is the bit nearest the output, new bits enter at the far end.
    logic [CL-1:0] chain = '0;
    assign scan_out = chain[0];
    always @(posedge clock) if (test) chain <= {scan_in, chain[CL-1:1]};

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cycles, test_cnt;
    logic [W-1:0]  tx [NB];
    logic [W-1:0]  rx [NB];
    logic [CL-1:0] exp_bits;   // chain contents in stream order, bit k returns as stream bit k

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_pass(input int is_byte, input int is_len, input int os_byte, input int os_len,
                            input bit poke, input bit chain_next, input bit pre_started,
                            input int abort_byte);
        int            in_idx = 0, out_idx = 0, iw = 0, ow = 0;
        bit            in_fire = 0, out_fire = 0, seen = 0, aborted = 0, finished = 0;
        logic [W-1:0]  hold = '0;
        logic [CL-1:0] txbits;
        for (int i = 0; i < NB; i++) txbits[i*W +: W] = tx[i];
        if (!pre_started) begin
            @(negedge clock);
            start = 1'b1;
        end
        cycles = 0;
        test_cnt = 0;
        while (!finished) begin
            @(negedge clock);
            cycles++;
            if (in_fire) begin in_idx++; iw = 0; end
            if (out_fire) begin out_idx++; ow = 0; seen = 0; end
            start = 1'b0;
            if (cycles == 1) begin
                check("busy_after_start", int'(busy), 1);
                check("in_ready_after_start", int'(in_ready), 1);
                check("done_single_cycle", int'(done), 0);
            end
            if (abort_byte >= 0 && test && test_cnt == abort_byte * W + 3) begin
                #2 reset = 1'b0;
                #1;
                check("abort_test", int'(test), 0);
                check("abort_busy", int'(busy), 0);
                check("abort_scan_in", int'(scan_in), 0);
                check("abort_out_valid", int'(out_valid), 0);
                check("abort_done", int'(done), 0);
                exp_bits = (exp_bits >> test_cnt) | (txbits << (CL - test_cnt));
                in_valid = 1'b0;
                out_ready = 1'b0;
                @(negedge clock);
                reset = 1'b1;
                repeat (3) begin
                    @(negedge clock);
                    check("post_abort_done", int'(done), 0);
                    check("post_abort_busy", int'(busy), 0);
                end
                aborted = 1;
                break;
            end
            if (test) test_cnt++;
            else check("scan_in_idle", int'(scan_in), 0);
            check("rdy_vld_excl", int'(in_ready && out_valid), 0);
            if (done) begin
                check("done_after_last", out_idx, NB);
                check("done_not_busy", int'(busy), 0);
                finished = 1;
                if (chain_next) start = 1'b1;
            end else begin
                check("busy_in_pass", int'(busy), 1);
            end
            if (in_ready) begin
                if (in_idx == is_byte && iw < is_len) begin
                    in_valid = 1'b0;
                    iw++;
                end else begin
                    in_valid = 1'b1;
                    in_data  = (in_idx < NB) ? tx[in_idx] : '0;
                end
            end else begin
                in_valid = 1'($urandom % 2);
                in_data  = W'($urandom);
            end
            if (out_valid) begin
                if (seen) check("out_stable", int'(out_data), int'(hold));
                else begin seen = 1; hold = out_data; end
                if (out_idx == os_byte && ow < os_len) begin
                    out_ready = 1'b0;
                    ow++;
                end else begin
                    out_ready = 1'b1;
                    if (out_idx < NB) rx[out_idx] = out_data;
                end
            end else begin
                out_ready = 1'($urandom % 2);
            end
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (poke && busy) start = 1'($urandom % 2);
            if (cycles > 3000) begin
                check("pass_timeout", 0, 1);
                finished = 1;
            end
        end
        if (!aborted) begin
            check("pass_cycles", cycles, 1 + 10 * NB + is_len + os_len);
            check("test_high_count", test_cnt, CL);
            for (int i = 0; i < NB; i++) check("rx_byte", int'(rx[i]), int'(exp_bits[i*W +: W]));
            exp_bits = txbits;
            if (!chain_next) begin
                @(negedge clock);
                check("done_one_cycle", int'(done), 0);
                in_valid = 1'b0;
                out_ready = 1'b0;
            end
        end
        $display("[TB] pass done: cycles=%0d test_cycles=%0d aborted=%0d", cycles, test_cnt, aborted);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        exp_bits = '0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_test", int'(test), 0);
        check("rst_scan_in", int'(scan_in), 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (10) begin
            @(negedge clock);
            check("idle_busy", int'(busy), 0);
            check("idle_test", int'(test), 0);
        end
        #3 reset = 1'b0;
        #1;
        check("mididle_rst_busy", int'(busy), 0);
        check("mididle_rst_test", int'(test), 0);
        check("mididle_rst_out_data", int'(out_data), 0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < NB; i++) tx[i] = W'(i);
        run_pass(-1, 0, -1, 0, 0, 0, 0, -1);
        for (int i = 0; i < NB; i++) tx[i] = '1;
        run_pass(-1, 0, -1, 0, 0, 0, 0, -1);
        for (int i = 0; i < NB; i++) tx[i] = (i == 0) ? W'(1) : '0;
        run_pass(-1, 0, -1, 0, 0, 0, 0, -1);
        run_pass(-1, 0, -1, 0, 0, 0, 0, -1);
        for (int i = 0; i < NB; i++) tx[i] = W'(8'h30 + i);
        run_pass(3, 5, 7, 3, 0, 0, 0, -1);
        for (int i = 0; i < NB; i++) tx[i] = W'($urandom);
        run_pass(-1, 0, -1, 0, 1, 1, 0, -1);
        for (int i = 0; i < NB; i++) tx[i] = W'($urandom);
        run_pass(-1, 0, -1, 0, 1, 0, 1, -1);
        for (int i = 0; i < NB; i++) tx[i] = W'($urandom);
        run_pass(-1, 0, -1, 0, 0, 0, 0, 5);
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NB; i++) tx[i] = W'($urandom);
            run_pass(int'($urandom % NB), int'($urandom % 4), int'($urandom % NB), int'($urandom % 4),
                     1'($urandom % 2), 0, 0, -1);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/scan_controller.md
# scan_controller

Bit-serial driver for the register file's scan chain, the initiator to the chain's scan port. On a start command it streams host bytes into the chain (test/scan_in) and simultaneously returns the bits shifted out of scan_out as bytes. A full pass replaces the entire chain contents and returns the previous contents, so one pass both loads and unloads. Sits between a byte-wide host (debug/test port) and the register file's scan pins.

## Interface

- DATA_BUS_WIDTH, 8, host byte width; also bits shifted per byte handshake.
- CHAIN_LENGTH, 96, scan chain length in bits; must be a multiple of DATA_BUS_WIDTH (default: 4 working registers plus 8 scanned bank registers, 8 bits each).

- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a pass; sampled only in IDLE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after a pass completes.
- in_data  input  DATA_BUS_WIDTH  next byte to shift in, LSB shifted first.
- in_valid  input  1  in_data valid.
- in_ready  output  1  controller accepts in_data.
- out_data  output  DATA_BUS_WIDTH  byte captured from scan_out, first captured bit in LSB.
- out_valid  output  1  out_data valid.
- out_ready  input  1  host accepts out_data.
- test  output  1  scan enable to chain; high only during shift cycles.
- scan_in  output  1  serial data into chain.
- scan_out  input  1  serial data from chain; combinational from chain state while test is high.

## Operation

- States: IDLE, LOAD, SHIFT, UNLOAD.
- IDLE: busy=0, in_ready=0, out_valid=0, test=0. start=1 -> LOAD, byte counter cleared. start in any other state ignored.
- LOAD: in_ready=1. On in_valid&in_ready, in_data loads shift register, bit counter cleared -> SHIFT. Otherwise hold; test stays 0.
- SHIFT: test=1, scan_in = shreg[0]. Each posedge: shreg <= {scan_out, shreg[W-1:1]}, bit counter +1. After the W-th shift edge -> UNLOAD.
- UNLOAD: out_valid=1, out_data = shreg (constant while out_valid). On out_valid&out_ready: if byte counter == CHAIN_LENGTH/W-1 -> IDLE with done pulse; else byte counter +1 -> LOAD.
- Stream order: stream bit k = byte[k/W][k%W]; bit k driven on shift k, and scan_out sampled at the same edge is returned bit k.
- After one full pass the chain holds exactly the sent stream; an immediate second pass returns it unchanged.
- Counters: bit counter $clog2(W)+1 bits, byte counter $clog2(CHAIN_LENGTH/W) bits, neither wraps; terminal compare only.
- During stalls (LOAD/UNLOAD) test=0, so the chain operates normally; system must hold the register file idle (no writes) while busy.
- scan_in = 0 whenever test=0.

## Timing

- Reset (asynchronous, immediate): state IDLE, busy=0, done=0, in_ready=0, out_valid=0, out_data=0, test=0, scan_in=0, counters and shift register 0. Reset mid-pass aborts, no done pulse, test drops without waiting for a clock edge.
- start at edge t -> busy and in_ready high from cycle t+1.
- Per byte minimum 10 cycles: 1 LOAD, W=8 SHIFT, 1 UNLOAD with zero-wait host.
- Minimum pass: 1 + 10*(CHAIN_LENGTH/W) cycles start-to-done (121 at defaults); done high in the first IDLE cycle after the last out handshake, exactly one cycle.
- test is high for exactly CHAIN_LENGTH cycles per pass regardless of stalls.
- in_ready and out_valid never high simultaneously.
- start asserted in the done cycle begins a new pass (state is IDLE).

## Test plan

- Reset: drive reset low mid-idle -> all outputs 0 immediately; release, no start -> busy stays 0, test never toggles.
- Load/unload against 96-bit behavioural chain reset to 0: pass 1 sends bytes 0x00..0x0B -> returns twelve 0x00; pass 2 sends twelve 0xFF -> returns 0x00..0x0B in order; done pulses once per pass, 121 cycles each with zero-wait host.
- Walking bit: send byte0=0x01, rest 0x00, then repeat pass -> second pass byte0=0x01, others 0x00; test high count = 96 per pass.
- Backpressure: delay in_valid 5 cycles before byte 3 and hold out_ready low 3 cycles on byte 7 -> test=0 throughout stalls, out_data stable while out_valid, returned data identical to zero-wait run.
- start pulsed while busy and during done cycle -> ignored while busy; done-cycle start begins a second pass.
- Reset asserted during SHIFT of byte 5 -> test and busy drop immediately, no done pulse; subsequent full pass completes normally.
